// File: rtl/jtag_ir_decode.sv
// jtag_ir_decode: parametrised JTAG instruction register with capture/shift
// on the rising edge of TCK, update and TDO on the falling edge, shift-length
// checking and a one-hot instruction decode.
module jtag_ir_decode #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS  = {IR_WIDTH{1'b1}},
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(8),
  parameter logic [IR_WIDTH-1:0] RESET_OP   = OP_IDCODE,
  parameter bit                  STRICT_LEN = 1'b1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic                TLR,
  input  logic                CAPTURE_IR,
  input  logic                SHIFT_IR,
  input  logic                UPDATE_IR,
  input  logic [IR_WIDTH-3:0] STATUS_IN,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                I_TDO,
  output logic                SEL_BYPASS,
  output logic                SEL_IDCODE,
  output logic                SEL_SAMPLE,
  output logic                SEL_EXTEST,
  output logic                SEL_USER,
  output logic                LEN_ERR
);

  // Counter is wide enough to hold IR_WIDTH+1, the "overlong shift" marker.
  localparam int               CNT_W    = $clog2(IR_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IR_WIDTH + 1);

  logic [IR_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tdo_q, tdo_d;
  logic [IR_WIDTH-1:0] latch_q, latch_d;
  logic                len_err_q, len_err_d;

  // Next shift-register and bit-count values: TLR > CAPTURE_IR > SHIFT_IR > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (TLR) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (CAPTURE_IR) begin
      sr_d  = {STATUS_IN, 2'b01};
      cnt_d = '0;
    end else if (SHIFT_IR) begin
      sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // Rising-edge state: shift register and bit counter.
  always_ff @(posedge TCK or posedge TRST) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (TRST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // Next instruction and length-error flag: TLR > UPDATE_IR > hold.
  always_comb begin
    tdo_d     = sr_q[0];
    latch_d   = latch_q;
    len_err_d = len_err_q;
    if (TLR) begin
      latch_d   = RESET_OP;
      len_err_d = 1'b0;
    end else if (UPDATE_IR) begin
      if (STRICT_LEN && (cnt_q != CNT_FULL)) begin
        // Short, overlong or empty shift: fall back to BYPASS and flag it.
        latch_d   = OP_BYPASS;
        len_err_d = 1'b1;
      end else begin
        latch_d   = sr_q;
        len_err_d = 1'b0;
      end
    end
  end

  // Falling-edge state: serial out, instruction latch and error flag.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q     <= 1'b0;
      latch_q   <= RESET_OP;
      len_err_q <= 1'b0;
    end else begin
      tdo_q     <= tdo_d;
      latch_q   <= latch_d;
      len_err_q <= len_err_d;
    end
  end

  // One-hot decode of the latched instruction; unknown opcodes select BYPASS.
  always_comb begin
    SEL_BYPASS = 1'b0;
    SEL_IDCODE = 1'b0;
    SEL_SAMPLE = 1'b0;
    SEL_EXTEST = 1'b0;
    SEL_USER   = 1'b0;
    if      (latch_q == OP_BYPASS) SEL_BYPASS = 1'b1;
    else if (latch_q == OP_IDCODE) SEL_IDCODE = 1'b1;
    else if (latch_q == OP_SAMPLE) SEL_SAMPLE = 1'b1;
    else if (latch_q == OP_EXTEST) SEL_EXTEST = 1'b1;
    else if (latch_q == OP_USER)   SEL_USER   = 1'b1;
    else                           SEL_BYPASS = 1'b1;
  end

  assign LATCH_IR = latch_q;
  assign I_TDO    = tdo_q;
  assign LEN_ERR  = len_err_q;

endmodule

// File: tb/tb_jtag_ir_decode.sv
// tb_jtag_ir_decode: strict and non-strict instances driven in lockstep,
// checked against a behavioural model of the instruction register.
module tb_jtag_ir_decode;

  logic       TCK = 1'b0;
  logic       TRST, TDI, TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR;
  logic [1:0] STATUS_IN;

  logic [3:0] latch_s, latch_n;
  logic       tdo_s, tdo_n, len_s, len_n;
  logic       sb_s, si_s, ss_s, se_s, su_s;
  logic       sb_n, si_n, ss_n, se_n, su_n;

  wire [4:0] sel_s = {sb_s, si_s, ss_s, se_s, su_s};
  wire [4:0] sel_n = {sb_n, si_n, ss_n, se_n, su_n};

  localparam logic [4:0] S_BYP = 5'b10000, S_IDC = 5'b01000, S_SMP = 5'b00100,
                         S_EXT = 5'b00010, S_USR = 5'b00001;

  jtag_ir_decode #(.STRICT_LEN(1'b1)) u_strict (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .TLR(TLR), .CAPTURE_IR(CAPTURE_IR),
    .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR), .STATUS_IN(STATUS_IN),
    .LATCH_IR(latch_s), .I_TDO(tdo_s), .SEL_BYPASS(sb_s), .SEL_IDCODE(si_s),
    .SEL_SAMPLE(ss_s), .SEL_EXTEST(se_s), .SEL_USER(su_s), .LEN_ERR(len_s));

  jtag_ir_decode #(.STRICT_LEN(1'b0)) u_loose (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .TLR(TLR), .CAPTURE_IR(CAPTURE_IR),
    .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR), .STATUS_IN(STATUS_IN),
    .LATCH_IR(latch_n), .I_TDO(tdo_n), .SEL_BYPASS(sb_n), .SEL_IDCODE(si_n),
    .SEL_SAMPLE(ss_n), .SEL_EXTEST(se_n), .SEL_USER(su_n), .LEN_ERR(len_n));

  always #5 TCK = ~TCK;

  int checks = 0;
  int failures = 0;

  // Reference model: integer shift value and bit count.
  int         m_sr, m_cnt;
  logic       m_tdo, m_len;
  logic [3:0] m_ls, m_ln;

  function automatic logic [4:0] exp_sel(input logic [3:0] op);
    case (op)
      4'hF:    return S_BYP;
      4'h1:    return S_IDC;
      4'h2:    return S_SMP;
      4'h0:    return S_EXT;
      4'h8:    return S_USR;
      default: return S_BYP;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = 0; m_cnt = 0; m_tdo = 1'b0; m_ls = 4'h1; m_ln = 4'h1; m_len = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tdo_s"},   tdo_s,   m_tdo);
    check({tag, ".tdo_n"},   tdo_n,   m_tdo);
    check({tag, ".latch_s"}, latch_s, m_ls);
    check({tag, ".latch_n"}, latch_n, m_ln);
    check({tag, ".sel_s"},   sel_s,   exp_sel(m_ls));
    check({tag, ".sel_n"},   sel_n,   exp_sel(m_ln));
    check({tag, ".len_s"},   len_s,   m_len);
    check({tag, ".len_n"},   len_n,   1'b0);
  endtask

  // One TAP state lasting one TCK period, starting just after a rising edge.
  task automatic step(input string tag, input bit tlr, input bit cap,
                      input bit sh, input bit upd, input bit tdi);
    TLR = tlr; CAPTURE_IR = cap; SHIFT_IR = sh; UPDATE_IR = upd; TDI = tdi;
    @(negedge TCK);
    m_tdo = m_sr[0];
    if (tlr) begin
      m_ls = 4'h1; m_ln = 4'h1; m_len = 1'b0;
    end else if (upd) begin
      m_ln = 4'(m_sr);
      if (m_cnt != 4) begin m_ls = 4'hF; m_len = 1'b1; end
      else begin m_ls = 4'(m_sr); m_len = 1'b0; end
    end
    #1;
    check_all(tag);
    @(posedge TCK);
    if (tlr) begin
      m_sr = 0; m_cnt = 0;
    end else if (cap) begin
      m_sr = STATUS_IN * 4 + 1; m_cnt = 0;
    end else if (sh) begin
      m_sr = (m_sr >> 1) + (tdi ? 8 : 0);
      m_cnt = (m_cnt + 1 > 5) ? 5 : m_cnt + 1;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Capture, shift n bits of val LSB first, then update.
  task automatic load(input string tag, input logic [7:0] val, input int n);
    logic [7:0] v;
    v = val;
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b1, 1'b0, v[i]);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [7:0] six_bits;

  initial begin
    TRST = 1'b1; TDI = 1'b0; TLR = 1'b0; CAPTURE_IR = 1'b0; SHIFT_IR = 1'b0;
    UPDATE_IR = 1'b0; STATUS_IN = 2'b00;
    model_reset();

    // 1: reset values, then hold after release.
    #2;
    check("rst.latch", latch_s, 4'h1);
    check("rst.sel",   sel_s,   S_IDC);
    check("rst.tdo",   tdo_s,   1'b0);
    check("rst.len",   len_s,   1'b0);
    @(posedge TCK); #1;
    TRST = 1'b0;
    idle("hold0");
    idle("hold1");

    // 2: capture status 01, four ones, update.
    STATUS_IN = 2'b01;
    step("cap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("sh0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); check("t2.tdo0", tdo_s, 1'b1);
    step("sh1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); check("t2.tdo1", tdo_s, 1'b0);
    step("sh2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); check("t2.tdo2", tdo_s, 1'b1);
    step("sh3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); check("t2.tdo3", tdo_s, 1'b0);
    step("upd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2.latch", latch_s, 4'hF);
    check("t2.sel",   sel_s,   S_BYP);
    check("t2.len",   len_s,   1'b0);

    // 3: short shift, then a correct SAMPLE load clears the flag.
    STATUS_IN = 2'b00;
    load("short", 8'h2, 3);
    check("t3.latch", latch_s, 4'hF);
    check("t3.len",   len_s,   1'b1);
    load("sample", 8'h2, 4);
    check("t3.sel", sel_s, S_SMP);
    check("t3.len_clr", len_s, 1'b0);

    // 4: overlong shift; strict falls back, loose keeps the last four bits.
    six_bits = 8'b0010_1101;
    load("long", six_bits, 6);
    check("t4.len", len_s, 1'b1);
    check("t4.sel", sel_s, S_BYP);
    check("t4.loose", latch_n, 4'hB);

    // 5: unknown opcode decodes as BYPASS but is shown raw.
    load("unk", 8'h5, 4);
    check("t5.latch", latch_s, 4'h5);
    check("t5.sel",   sel_s,   S_BYP);

    // 6: USER, then TLR mid-shift, then update with an empty shift.
    load("user", 8'h8, 4);
    check("t6.sel", sel_s, S_USR);
    step("c6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("s6a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("s6b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("tlr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6.tlr_latch", latch_s, 4'h1);
    idle("post_tlr");
    check("t6.tlr_tdo", tdo_s, 1'b0);
    step("upd0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6.cnt0_len", len_s, 1'b1);
    check("t6.cnt0_loose", latch_n, 4'h0);

    // Async TRST mid-shift takes effect without a clock edge.
    load("user2", 8'h8, 4);
    step("c7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("s7", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    SHIFT_IR = 1'b1; TDI = 1'b1;
    #2 TRST = 1'b1;
    #1;
    model_reset();
    check("trst.latch", latch_s, 4'h1);
    check("trst.sel",   sel_s,   S_IDC);
    check("trst.tdo",   tdo_s,   1'b0);
    check("trst.len",   len_s,   1'b0);
    @(posedge TCK); #1;
    TRST = 1'b0;
    // Fresh shift without capture must count from zero.
    for (int i = 0; i < 4; i++) step("rs", 1'b0, 1'b0, 1'b1, 1'b0, (i == 1));
    step("rs_upd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("trst.restart", sel_s, S_SMP);

    // Random mix of states, including illegal simultaneous strobes.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      STATUS_IN = 2'($urandom);
      if (r < 60)
        step("rnd", 1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
      else if (r < 72)
        step("rnd", 1'b0, 1'b1, 1'($urandom), 1'b0, 1'($urandom));
      else if (r < 86)
        step("rnd", 1'b0, 1'b0, 1'($urandom), 1'b1, 1'($urandom));
      else if (r < 92)
        step("rnd", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else if (r < 97)
        load("rnd_ld", 8'($urandom), 4);
      else
        idle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
